// File: rtl/sdpb_stream_reader_pkg.sv
// Shared definitions for the sample-RAM stream reader: default geometry
// of the 1024x18 simple dual-port sample RAM and the reader FSM states.
package sdpb_stream_reader_pkg;

  localparam int SDPB_ADDR_W     = 10;
  localparam int SDPB_DATA_W     = 18;
  localparam int SDPB_LEN_W      = 11;
  localparam int SDPB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sdpb_rd_fifo.sv
// Small synchronous FIFO that buffers RAM read data (plus last flag) ahead
// of the output stream. Flush has priority over push and pop.
module sdpb_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign do_pop   = pop && (occ_q != '0);
  assign do_push  = push && (occ_q < OCC_W'(DEPTH));
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = (occ_q != '0);
  assign occ      = occ_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is only a few flops, so it is reset to give a defined m_data after reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/sdpb_stream_reader.sv
// Read-side controller for the sample RAM: on start, reads a burst from
// port B (wrapping modulo depth) and streams it out with valid/ready/last.
// A credit check against FIFO occupancy plus the in-flight read keeps the
// FIFO from overflowing under sink backpressure.
module sdpb_stream_reader
  import sdpb_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = SDPB_ADDR_W,
  parameter int DATA_W     = SDPB_DATA_W,
  parameter int LEN_W      = SDPB_LEN_W,
  parameter int FIFO_DEPTH = SDPB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_ceb,
  output logic              ram_oce,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic              inflight_q, inflight_d;
  logic              last_inflight_q, last_inflight_d;

  logic [OCC_W-1:0]  fifo_occ;
  logic [DATA_W:0]   fifo_rd;
  logic              fifo_flush, fifo_pop, fifo_valid;
  logic              credit_ok, final_issue;

  assign credit_ok   = (fifo_occ + OCC_W'(inflight_q)) < OCC_W'(FIFO_DEPTH);
  assign final_issue = (issue_cnt_q == len_q - LEN_W'(1));
  assign ram_adb     = addr_q;
  assign ram_oce     = 1'b1;
  assign m_valid     = fifo_valid;
  assign m_data      = fifo_rd[DATA_W-1:0];
  assign m_last      = fifo_valid & fifo_rd[DATA_W];
  assign fifo_pop    = m_valid && m_ready;

  // FSM next-state, read issue and status outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    ram_ceb     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fifo_flush  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          len_d       = length;
          issue_cnt_d = '0;
          state_d     = (length == '0) ? FIN : READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        ram_ceb = !abort && (issue_cnt_q < len_q) && credit_ok;
        if (ram_ceb) begin
          addr_d      = addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
          if (final_issue) state_d = DRAIN;
        end
        if (abort) begin
          fifo_flush = 1'b1;
          state_d    = FIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          fifo_flush = 1'b1;
          state_d    = FIN;
        end else if (fifo_pop && m_last) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    inflight_d      = ram_ceb;
    last_inflight_d = ram_ceb && final_issue;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
    end
  end

  // Read data lands one cycle after each issue; an abort flush discards it.
  sdpb_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data ({last_inflight_q, ram_dout}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .rd_data   (fifo_rd),
    .rd_valid  (fifo_valid),
    .occ       (fifo_occ)
  );

endmodule

// File: tb/tb_sdpb_stream_reader.sv
// Self-checking bench for sdpb_stream_reader: a behavioural RAM, an
// expected-word queue per burst and an issue/accept credit model.
module tb_sdpb_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        abort = 1'b0;
  logic        busy, done, ram_ceb, ram_oce, m_valid, m_last;
  logic [9:0]  ram_adb;
  logic [17:0] ram_dout = '0;
  logic [17:0] m_data;
  logic        m_ready = 1'b0;

  sdpb_stream_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ram_adb   (ram_adb),
    .ram_ceb   (ram_ceb),
    .ram_oce   (ram_oce),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Behavioural port-B RAM: data appears the cycle after the enable cycle.
  logic [17:0] ram [1024];
  always @(posedge clk) if (ram_ceb) ram_dout <= ram[ram_adb];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [18:0] exp_q [$];
  int cur_base, cur_len, issued, accepted;
  int start_cyc, first_ceb_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
  int done_cnt, beats, busy_cnt;
  bit prev_stall;
  logic [17:0] prev_data;
  logic prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ceb"}, ram_ceb, 0);
    check({tag, "_adb"}, ram_adb, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_data"}, m_data, 0);
  endtask

  // One clock cycle: observe mid-cycle, then advance past the next edge.
  task automatic step();
    logic [18:0] e;
    @(negedge clk);
    check("oce_tied", ram_oce, 1);
    if (ram_ceb) begin
      check("ceb_addr", ram_adb, (cur_base + issued) % 1024);
      check("ceb_credit", (issued - accepted) < 4, 1);
      check("ceb_count", issued < cur_len, 1);
      if (first_ceb_cyc < 0) first_ceb_cyc = cyc;
      issued++;
    end
    if (prev_stall) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid && m_ready) begin
      check("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat_data", m_data, e[17:0]);
        check("beat_last", m_last, e[18]);
      end
      accepted++;
      beats++;
      if (m_last) last_beat_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_busy_low", busy, 0);
    end
    prev_stall = m_valid && !m_ready && !abort;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_burst(input int base, input int len);
    bit l;
    cur_base = base; cur_len = len; issued = 0; accepted = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      l = (i == len - 1);
      exp_q.push_back({l, ram[(base + i) % 1024]});
    end
    first_ceb_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    done_cnt = 0; beats = 0; busy_cnt = 0; prev_stall = 0;
    base_addr = 10'(base);
    length = 11'(len);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  // mode 0: m_ready held high; mode 1: 10 stalled cycles then random ready.
  task automatic finish_burst(input int mode);
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      if (mode == 0) m_ready = 1'b1;
      else m_ready = (k >= 2 && k < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end
    check("burst_done_seen", done_cnt > 0, 1);
    m_ready = 1'b1;
    step();
    step();
    check("single_done", done_cnt, 1);
    check("beat_count", beats, cur_len);
    check("queue_empty", exp_q.size(), 0);
    check("issue_count", issued, cur_len);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 18'($urandom);

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic burst: latency and address sequence.
    m_ready = 1'b1;
    begin_burst(5, 4);
    check("t1_busy_n1", busy, 1);
    check("t1_ceb_n1", ram_ceb, 1);
    check("t1_adb_n1", ram_adb, 5);
    finish_burst(0);
    check("t1_first_ceb", first_ceb_cyc - start_cyc, 1);
    check("t1_first_valid", first_valid_cyc - start_cyc, 3);
    check("t1_last_beat", last_beat_cyc - start_cyc, 6);
    check("t1_done_after_last", done_cyc - last_beat_cyc, 1);
    check("t1_busy_cycles", busy_cnt, 6);

    // Address wrap across the top of the buffer.
    begin_burst(1022, 5);
    finish_burst(0);

    // Zero-length burst.
    begin_burst($urandom_range(0, 1023), 0);
    check("t3_busy", busy, 0);
    check("t3_done", done, 1);
    finish_burst(0);
    check("t3_done_cyc", done_cyc - start_cyc, 1);
    check("t3_no_valid", first_valid_cyc, -1);
    check("t3_busy_cnt", busy_cnt, 0);

    // Backpressure with a long stall.
    begin_burst($urandom_range(0, 1023), 16);
    finish_burst(1);

    // Random bursts under random backpressure.
    for (int r = 0; r < 4; r++) begin
      begin_burst($urandom_range(0, 1023), $urandom_range(1, 40));
      finish_burst(1);
    end

    // Abort three cycles into a long stalled burst.
    m_ready = 1'b0;
    begin_burst($urandom_range(0, 1023), 100);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_ceb_low", ram_ceb, 0);
    check("abort_valid_low", m_valid, 0);
    check("abort_done", done, 1);
    check("abort_busy_low", busy, 0);
    for (int k = 0; k < 4; k++) step();
    check("abort_single_done", done_cnt, 1);
    check("abort_no_beats", beats, 0);
    m_ready = 1'b1;
    begin_burst(0, 2);
    finish_burst(0);

    // Asynchronous reset in the middle of a burst.
    m_ready = 1'b0;
    begin_burst(100, 20);
    for (int k = 0; k < 4; k++) step();
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    cur_len = 0; issued = 0; accepted = 0; exp_q.delete();
    done_cnt = 0; busy_cnt = 0; prev_stall = 0;
    for (int k = 0; k < 3; k++) step();
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_busy", busy_cnt, 0);

    // A start pulsed during FIN is ignored.
    m_ready = 1'b1;
    begin_burst(7, 3);
    for (int k = 0; k < 50 && done !== 1'b1; k++) step();
    check("fin_reached", done, 1);
    cur_len = 0; issued = 0; accepted = 0; busy_cnt = 0; done_cnt = 0;
    base_addr = 10'd9;
    length = 11'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("fin_start_busy", busy_cnt, 0);
    check("fin_start_issue", issued, 0);
    check("fin_start_done", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
